// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - request/result bundle between the HI/LO unit and the divider
interface div_seq_if #(
    parameter int BIT_WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [BIT_WIDTH-1:0]   inA;
    logic [BIT_WIDTH-1:0]   inB;
    logic                   busy;
    logic                   done;
    logic [2*BIT_WIDTH-1:0] out;

    modport master (
        output start, is_signed, inA, inB,
        input  busy, done, out
    );

    modport slave (
        input  start, is_signed, inA, inB,
        output busy, done, out
    );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring divider for DIV/DIVU, out = {remainder, quotient}
module div_seq #(
    parameter int BIT_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);
    localparam int W  = BIT_WIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [2*W-1:0]   out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [W:0]       trial;
    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;
    logic [W-1:0]     q_fix;
    logic [W-1:0]     r_fix;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        out_d   = out_q;

        // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
        abs_a = (bus.is_signed && bus.inA[W-1]) ? -bus.inA : bus.inA;
        abs_b = (bus.is_signed && bus.inB[W-1]) ? -bus.inB : bus.inB;
        // The partial remainder stays below the divisor, so W+1 bits never overflow.
        trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
        // Divide-by-zero keeps the all-ones quotient unsigned-looking.
        q_fix = ((sa_q ^ sb_q) && (dvs_q != '0)) ? -quo_q : quo_q;
        r_fix = sa_q ? -rem_q : rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.is_signed & bus.inA[W-1];
                    sb_d    = bus.is_signed & bus.inB[W-1];
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    rem_d   = '0;
                    count_d = CW'(W - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!trial[W]) begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[W-2:0], quo_q[W-1]};
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                out_d   = {r_fix, q_fix};
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_seq_if #(.BIT_WIDTH(32)) dif ();
    div_seq #(.BIT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int inject_at, output logic [63:0] res);
        int   guard;
        int   lat;
        logic busy_ok;
        guard = 0;
        while (dif.busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        dif.start     = 1'b1;
        dif.inA       = a;
        dif.inB       = b;
        dif.is_signed = s;
        @(posedge clk);
        #1;
        dif.start     = 1'b0;
        dif.inA       = $urandom;
        dif.inB       = $urandom;
        dif.is_signed = 1'($urandom_range(0, 1));
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            dif.start = (inject_at != 0 && lat == inject_at);
            if (dif.busy !== 1'b1) busy_ok = 1'b0;
            if (dif.done === 1'b1) break;
        end
        dif.start = 1'b0;
        res = dif.out;
        check("latency", 64'(lat), 64'd34);
        check("busy_during_op", {63'd0, busy_ok}, 64'd1);
    endtask

    initial begin
        logic [63:0] res;
        logic [31:0] ra, rb;
        logic        rs;
        int          seen;

        dif.start = 1'b0;
        dif.is_signed = 1'b0;
        dif.inA = '0;
        dif.inB = '0;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
        vecs[4] = '{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0};
        vecs[8] = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0};
        vecs[9] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, dif.busy}, 64'd0);
        check("reset_done", {63'd0, dif.done}, 64'd0);
        check("reset_out", dif.out, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, res);
            check($sformatf("vec%0d", i), res, {vecs[i].r, vecs[i].q});
        end

        @(negedge clk);
        check("idle_busy", {63'd0, dif.busy}, 64'd0);
        check("idle_done", {63'd0, dif.done}, 64'd0);

        // Start during an op with different operands must be dropped.
        run_op(32'd100, 32'd7, 1'b0, 10, res);
        check("ignored_start", res, {32'd2, 32'd14});
        run_op(32'd1000, 32'd10, 1'b0, 0, res);
        check("back_to_back", res, {32'd0, 32'd100});
        repeat (4) @(negedge clk);
        check("out_held", dif.out, {32'd0, 32'd100});
        check("held_busy", {63'd0, dif.busy}, 64'd0);

        // Reset mid-divide.
        dif.start = 1'b1;
        dif.inA = 32'd12345;
        dif.inB = 32'd3;
        dif.is_signed = 1'b0;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {63'd0, dif.busy}, 64'd0);
        check("rst_done", {63'd0, dif.done}, 64'd0);
        check("rst_out", dif.out, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);
        run_op(32'hFFFF_FFFF, 32'd16, 1'b0, 0, res);
        check("post_rst_divu", res, {32'd15, 32'h0FFF_FFFF});

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'($urandom_range(0, 9));
                1:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb, rs, 0, res);
            check($sformatf("rand%0d a=%h b=%h s=%0d", i, ra, rb, rs), res, ref_div(ra, rb, rs));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
